// File: rtl/_tree_encoder_pipe_pkg.sv
// Shared helpers for the pipelined tree priority encoder: max macro and
// the level count used to size the index and the pipeline depth.
`ifndef MAX
`define MAX(a, b) (((a) > (b)) ? (a) : (b))
`endif

package _tree_encoder_pipe_pkg;

    // Number of tree levels (= index width = stages) for a w-bit request vector.
    function automatic int enc_levels(int w);
        int n;
        int l;
        n = `MAX(w, 2);
        l = 0;
        while ((1 << l) < n) l++;
        return l;
    endfunction

endpackage

// File: rtl/_tree_encoder_pipe_stage.sv
// One tree level: combines node pairs from the previous level (or passes the
// already-paired level 0 through) into a registered {valid, any, idx} stage.
module _tree_encoder_stage #(
    parameter int nodes_in = 2,
    parameter int idx_w    = 1,
    localparam int IIW     = `MAX(idx_w - 1, 1),
    localparam int NO      = (idx_w == 1) ? nodes_in : nodes_in / 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_vld,
    input  logic [nodes_in-1:0]    in_any,
    input  logic [nodes_in*IIW-1:0] in_idx,
    input  logic                   dn_ld,
    output logic                   ld,
    output logic                   vld_q,
    output logic [NO-1:0]          any_q,
    output logic [NO*idx_w-1:0]    idx_q
);

    logic [NO-1:0]       any_c;
    logic [NO*idx_w-1:0] idx_c;
    logic                vld_d;
    logic [NO-1:0]       any_d;
    logic [NO*idx_w-1:0] idx_d;

    if (idx_w == 1) begin : g_pass
        assign any_c = in_any;
        assign idx_c = in_idx;
    end else begin : g_comb
        for (genvar j = 0; j < NO; j++) begin : g_node
            logic           la, ua;
            logic [IIW-1:0] li, ui;
            assign la = in_any[2*j];
            assign ua = in_any[2*j+1];
            assign li = in_idx[2*j*IIW +: IIW];
            assign ui = in_idx[(2*j+1)*IIW +: IIW];
            assign any_c[j] = la | ua;
            // Upper prefix bit is U.any so an all-zero subtree collapses to index 0.
            assign idx_c[j*idx_w +: idx_w] = la ? {1'b0, li} : {ua, ui};
        end
    end

    assign ld = !vld_q || dn_ld;

    always_comb begin
        vld_d = vld_q;
        any_d = any_q;
        idx_d = idx_q;
        if (ld) begin
            vld_d = in_vld;
            if (in_vld) begin
                any_d = any_c;
                idx_d = idx_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            any_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            any_q <= any_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/_tree_encoder_pipe.sv
// Pipelined binary-tree priority encoder: index of the lowest set bit plus an
// any flag, one register stage per tree level, valid/ready on both ends.
module _tree_encoder_pipe
    import _tree_encoder_pipe_pkg::*;
#(
    parameter int input_width = 8,
    localparam int IW         = enc_levels(input_width),
    localparam int PW         = 1 << IW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [input_width-1:0] in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [IW-1:0]          out,
    output logic                   any,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [PW-1:0] in_pad;
    logic [IW:0]   ld;

    always_comb begin
        in_pad = '0;
        in_pad[input_width-1:0] = in;
    end

    assign ld[IW] = out_ready;

    for (genvar k = 0; k < IW; k++) begin : g_lvl
        localparam int NI = (k == 0) ? PW / 2 : (PW >> k);
        localparam int NO = (k == 0) ? NI : NI / 2;
        localparam int OW = k + 1;

        logic               vld_q;
        logic [NO-1:0]      any_q;
        logic [NO*OW-1:0]   idx_q;

        if (k == 0) begin : g_src
            logic [NI-1:0] p_any;
            logic [NI-1:0] p_idx;

            always_comb begin
                for (int j = 0; j < NI; j++) begin
                    p_any[j] = in_pad[2*j] | in_pad[2*j+1];
                    p_idx[j] = ~in_pad[2*j] & in_pad[2*j+1];
                end
            end

            _tree_encoder_stage #(.nodes_in(NI), .idx_w(1)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .in_vld (in_valid),
                .in_any (p_any),
                .in_idx (p_idx),
                .dn_ld  (ld[k+1]),
                .ld     (ld[k]),
                .vld_q  (vld_q),
                .any_q  (any_q),
                .idx_q  (idx_q)
            );
        end else begin : g_src
            _tree_encoder_stage #(.nodes_in(NI), .idx_w(OW)) u_stage (
                .clk    (clk),
                .rst_n  (rst_n),
                .in_vld (g_lvl[k-1].vld_q),
                .in_any (g_lvl[k-1].any_q),
                .in_idx (g_lvl[k-1].idx_q),
                .dn_ld  (ld[k+1]),
                .ld     (ld[k]),
                .vld_q  (vld_q),
                .any_q  (any_q),
                .idx_q  (idx_q)
            );
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = g_lvl[IW-1].vld_q;
    assign any       = g_lvl[IW-1].any_q[0];
    assign out       = g_lvl[IW-1].idx_q;

endmodule

// File: tb/tb__tree_encoder_pipe.sv
// Self-checking bench for the tree priority encoder: vector table, odd widths,
// backpressure, randomized scoreboard and mid-flight reset.
module tb__tree_encoder_pipe;
    import _tree_encoder_pipe_pkg::*;

    localparam int IW8 = enc_levels(8);
    localparam int IW5 = enc_levels(5);
    localparam int IW1 = enc_levels(1);

    logic clk, rst_n;

    logic [7:0]     in8;
    logic           iv8, ir8, ov8, or8, any8;
    logic [IW8-1:0] out8;
    logic [4:0]     in5;
    logic           iv5, ir5, ov5, or5, any5;
    logic [IW5-1:0] out5;
    logic           in1;
    logic           iv1, ir1, ov1, or1, any1;
    logic [IW1-1:0] out1;

    _tree_encoder_pipe #(.input_width(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .in_valid(iv8), .in_ready(ir8),
        .out(out8), .any(any8), .out_valid(ov8), .out_ready(or8));
    _tree_encoder_pipe #(.input_width(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in(in5), .in_valid(iv5), .in_ready(ir5),
        .out(out5), .any(any5), .out_valid(ov5), .out_ready(or5));
    _tree_encoder_pipe #(.input_width(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .in_valid(iv1), .in_ready(ir1),
        .out(out1), .any(any1), .out_valid(ov1), .out_ready(or1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required normal finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] din;
        logic [2:0] eout;
        logic       eany;
    } vec_t;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] q[$];
    int         dcount = 0;
    logic       stall_prev = 1'b0;
    logic [IW8-1:0] prev_out;
    logic       prev_any;

    function automatic int ref_idx(logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One cycle on the W=8 instance, scoreboarded against the queue model.
    task automatic cyc8(input logic vin, input logic [7:0] din, input logic ordy, output logic acc);
        logic [7:0] head;
        @(negedge clk);
        iv8 = vin; in8 = din; or8 = ordy;
        #1;
        chk("in_ready", ir8, (q.size() < IW8) || ordy);
        if (stall_prev) begin
            chk("hold_valid", ov8, 1);
            chk("hold_out", out8, prev_out);
            chk("hold_any", any8, prev_any);
        end
        if (ov8) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL spurious_valid: out_valid=1 with no result outstanding, expected 0");
            end else begin
                head = q[0];
                chk("sb_out", out8, ref_idx(head));
                chk("sb_any", any8, |head);
                if (ordy) begin
                    head = q.pop_front();
                    dcount++;
                end
            end
        end
        stall_prev = ov8 && !ordy;
        prev_out   = out8;
        prev_any   = any8;
        acc = vin && ir8;
        if (acc) q.push_back(din);
        @(posedge clk);
    endtask

    vec_t       tab[11];
    logic [7:0] d6[6];
    logic       a;
    int         acc_n;
    int         mode;
    logic [7:0] rv;

    initial begin
        for (int i = 0; i < 8; i++) begin
            tab[i].din  = 8'b1 << i;
            tab[i].eout = 3'(i);
            tab[i].eany = 1'b1;
        end
        tab[8]  = '{8'b1010_1000, 3'd3, 1'b1};
        tab[9]  = '{8'b1000_0000, 3'd7, 1'b1};
        tab[10] = '{8'b0000_0000, 3'd0, 1'b0};
        d6 = '{8'h01, 8'h06, 8'h30, 8'h00, 8'hC0, 8'h81};

        // Reset with inputs offered.
        rst_n = 1'b0;
        iv8 = 1'b1; in8 = 8'hFF; or8 = 1'b1;
        iv5 = 1'b1; in5 = 5'h1F; or5 = 1'b1;
        iv1 = 1'b1; in1 = 1'b1;  or1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", ov8, 0);
        chk("rst_out", out8, 0);
        chk("rst_any", any8, 0);
        chk("rst_out_valid5", ov5, 0);
        chk("rst_out_valid1", ov1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        iv8 = 1'b0; iv5 = 1'b0; iv1 = 1'b0;
        #1;
        chk("rst_in_ready", ir8, 1);

        // Back-to-back table: result i must appear just before edge i+3.
        for (int c = 0; c < 11 + 3; c++) begin
            @(negedge clk);
            if (c < 11) begin iv8 = 1'b1; in8 = tab[c].din; end
            else iv8 = 1'b0;
            or8 = 1'b1;
            #1;
            if (c < 11) chk("tab_in_ready", ir8, 1);
            if (c < 3) chk("tab_lat_empty", ov8, 0);
            else begin
                chk("tab_valid", ov8, 1);
                chk("tab_out", out8, tab[c-3].eout);
                chk("tab_any", any8, tab[c-3].eany);
            end
            @(posedge clk);
        end

        // Odd widths.
        @(negedge clk);
        iv8 = 1'b0;
        iv5 = 1'b1; in5 = 5'b10000;
        iv1 = 1'b1; in1 = 1'b1;
        #1;
        chk("w5_in_ready", ir5, 1);
        chk("w1_in_ready", ir1, 1);
        @(negedge clk);
        iv5 = 1'b0; iv1 = 1'b0;
        #1;
        chk("w1_valid", ov1, 1);
        chk("w1_out", out1, 0);
        chk("w1_any", any1, 1);
        chk("w5_early", ov5, 0);
        @(negedge clk);
        #1;
        chk("w5_early2", ov5, 0);
        chk("w1_drained", ov1, 0);
        @(negedge clk);
        #1;
        chk("w5_valid", ov5, 1);
        chk("w5_out", out5, 4);
        chk("w5_any", any5, 1);
        @(posedge clk);

        // Backpressure: full pipe stalls input, then alternate out_ready.
        acc_n = 0; dcount = 0;
        for (int c = 0; c < 5; c++) begin
            cyc8(1'b1, d6[acc_n], 1'b0, a);
            if (a) acc_n++;
        end
        chk("bp_accepts", acc_n, 3);
        @(negedge clk);
        #1;
        chk("bp_in_ready_low", ir8, 0);
        for (int c = 0; c < 60 && dcount < 6; c++) begin
            cyc8(acc_n < 6, (acc_n < 6) ? d6[acc_n] : 8'h00, (c % 2) == 0, a);
            if (a) acc_n++;
        end
        chk("bp_delivered", dcount, 6);
        chk("bp_empty", q.size(), 0);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            mode = $urandom_range(0, 3);
            if (mode == 0) rv = 8'h00;
            else if (mode == 1) rv = 8'b1 << $urandom_range(0, 7);
            else rv = 8'($urandom);
            cyc8($urandom_range(0, 9) < 7, rv, $urandom_range(0, 9) < 6, a);
        end
        for (int c = 0; c < 20 && q.size() > 0; c++) cyc8(1'b0, 8'h00, 1'b1, a);
        chk("rand_drained", q.size(), 0);

        // Mid-flight reset discards everything in the pipe.
        for (int k = 0; k < 3; k++) cyc8(1'b1, 8'h02 << k, 1'b1, a);
        @(negedge clk);
        iv8 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid_low", ov8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        stall_prev = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("mrst_flush", ov8, 0);
        end
        dcount = 0;
        cyc8(1'b1, 8'h40, 1'b1, a);
        chk("mrst_accept", a, 1);
        for (int c = 0; c < 10 && dcount < 1; c++) cyc8(1'b0, 8'h00, 1'b1, a);
        chk("mrst_result", dcount, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
